// File: rtl/fb_sdram_bridge.sv
// fb_sdram_bridge: framebuffer memory slave that maps the CPU framebuffer port onto a dedicated
// SDRAM word port (rd/wr pulses, busy, rdata_valid).
// Writes are posted into a small FIFO and acknowledged early. Partial-word writes become
// read-modify-write sequences. In-range reads first wait for the FIFO to drain, so the CPU
// always sees its own writes.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   fb_mem_*             CPU framebuffer port (valid/addr/wdata/wstrb in; rdata/ready out)
//   sd_rd, sd_wr         one-cycle registered command pulses to the SDRAM controller
//   sd_addr, sd_wdata    command address/data, held until the next command
//   sd_rdata, sd_busy,
//   sd_rdata_valid       SDRAM controller responses
//   fb_idle              FIFO empty and back-end idle
module fb_sdram_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [23:0] FB_BASE    = 24'h200000,
    parameter int unsigned FB_WORDS   = 38400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fb_mem_valid,
    input  logic [31:0] fb_mem_addr,
    input  logic [31:0] fb_mem_wdata,
    input  logic [3:0]  fb_mem_wstrb,
    output logic [31:0] fb_mem_rdata,
    output logic        fb_mem_ready,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [23:0] sd_addr,
    output logic [31:0] sd_wdata,
    input  logic [31:0] sd_rdata,
    input  logic        sd_busy,
    input  logic        sd_rdata_valid,
    output logic        fb_idle
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] F_IDLE    = 3'd0;
    localparam logic [2:0] F_RD_WAIT = 3'd1;
    localparam logic [2:0] F_RD_DATA = 3'd2;
    localparam logic [2:0] F_RESP    = 3'd3;
    localparam logic [2:0] F_GAP     = 3'd4;

    localparam logic [1:0] B_IDLE    = 2'd0;
    localparam logic [1:0] B_RD      = 2'd1;
    localparam logic [1:0] B_WR_ARM  = 2'd2;
    localparam logic [1:0] B_WR_DONE = 2'd3;

    logic [2:0]  front_q, front_d;
    logic [1:0]  back_q, back_d;
    logic [31:0] rdata_q, rdata_d;
    logic [16:0] rd_widx_q, rd_widx_d;
    logic        tag_rmw_q, tag_rmw_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic [23:0] sd_addr_q, sd_addr_d;
    logic [31:0] sd_wdata_q, sd_wdata_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    logic [16:0] fifo_widx_q  [FIFO_DEPTH];
    logic [31:0] fifo_wdata_q [FIFO_DEPTH];
    logic [3:0]  fifo_wstrb_q [FIFO_DEPTH];

    logic [16:0] req_widx;
    logic        req_write, req_in_range;
    logic        fifo_empty, fifo_full;
    logic [16:0] head_widx;
    logic [31:0] head_wdata, merged;
    logic [3:0]  head_wstrb;
    logic        push, pop, cpu_req, rd_done;
    logic [16:0] cpu_widx;
    logic        unused_addr;

    assign req_widx     = fb_mem_addr[18:2];
    assign req_write    = |fb_mem_wstrb;
    assign req_in_range = {15'd0, req_widx} < FB_WORDS;
    assign unused_addr  = ^{fb_mem_addr[31:19], fb_mem_addr[1:0]};

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_widx  = fifo_widx_q[rptr_q[AW-1:0]];
    assign head_wdata = fifo_wdata_q[rptr_q[AW-1:0]];
    assign head_wstrb = fifo_wstrb_q[rptr_q[AW-1:0]];

    assign fb_idle = fifo_empty && (back_q == B_IDLE);
    assign rd_done = (back_q == B_RD) && !tag_rmw_q && sd_rdata_valid;

    assign fb_mem_ready = (front_q == F_RESP);
    assign fb_mem_rdata = rdata_q;
    assign sd_rd        = sd_rd_q;
    assign sd_wr        = sd_wr_q;
    assign sd_addr      = sd_addr_q;
    assign sd_wdata     = sd_wdata_q;

    // Front FSM: CPU side. valid is only looked at in F_IDLE.
    always_comb begin
        front_d   = front_q;
        rdata_d   = rdata_q;
        rd_widx_d = rd_widx_q;
        push      = 1'b0;
        cpu_req   = 1'b0;
        cpu_widx  = req_widx;
        case (front_q)
            F_IDLE: begin
                if (fb_mem_valid) begin
                    if (!req_in_range) begin
                        front_d = F_RESP;
                        rdata_d = '0;
                    end else if (req_write) begin
                        if (!fifo_full) begin
                            push    = 1'b1;
                            front_d = F_RESP;
                            rdata_d = '0;
                        end
                    end else begin
                        rd_widx_d = req_widx;
                        if (fb_idle) begin
                            cpu_req = 1'b1;
                            front_d = F_RD_DATA;
                        end else begin
                            front_d = F_RD_WAIT;
                        end
                    end
                end
            end
            F_RD_WAIT: begin
                if (fb_idle) begin
                    cpu_req  = 1'b1;
                    cpu_widx = rd_widx_q;
                    front_d  = F_RD_DATA;
                end
            end
            F_RD_DATA: begin
                if (rd_done) begin
                    rdata_d = sd_rdata;
                    front_d = F_RESP;
                end
            end
            F_RESP:  front_d = F_GAP;
            F_GAP: begin
                front_d = F_IDLE;
                rdata_d = '0;
            end
            default: front_d = F_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = head_wstrb[i] ? head_wdata[8*i +: 8] : sd_rdata[8*i +: 8];
        end
    end

    // Back FSM: SDRAM side. A CPU read only arrives while the FIFO is empty.
    always_comb begin
        back_d     = back_q;
        tag_rmw_d  = tag_rmw_q;
        sd_rd_d    = 1'b0;
        sd_wr_d    = 1'b0;
        sd_addr_d  = sd_addr_q;
        sd_wdata_d = sd_wdata_q;
        pop        = 1'b0;
        case (back_q)
            B_IDLE: begin
                if (cpu_req) begin
                    sd_rd_d   = 1'b1;
                    sd_addr_d = FB_BASE + {7'd0, cpu_widx};
                    tag_rmw_d = 1'b0;
                    back_d    = B_RD;
                end else if (!fifo_empty) begin
                    sd_addr_d = FB_BASE + {7'd0, head_widx};
                    if (head_wstrb == 4'hF) begin
                        sd_wr_d    = 1'b1;
                        sd_wdata_d = head_wdata;
                        back_d     = B_WR_ARM;
                    end else begin
                        sd_rd_d   = 1'b1;
                        tag_rmw_d = 1'b1;
                        back_d    = B_RD;
                    end
                end
            end
            B_RD: begin
                if (sd_rdata_valid) begin
                    if (tag_rmw_q) begin
                        sd_wr_d    = 1'b1;
                        sd_wdata_d = merged;
                        back_d     = B_WR_ARM;
                    end else begin
                        back_d = B_IDLE;
                    end
                end
            end
            B_WR_ARM: begin
                if (sd_busy) back_d = B_WR_DONE;
            end
            B_WR_DONE: begin
                if (!sd_busy) begin
                    pop    = 1'b1;
                    back_d = B_IDLE;
                end
            end
            default: back_d = B_IDLE;
        endcase
    end

    assign wptr_d = wptr_q + {{AW{1'b0}}, push};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_q    <= F_IDLE;
            back_q     <= B_IDLE;
            rdata_q    <= '0;
            rd_widx_q  <= '0;
            tag_rmw_q  <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            front_q    <= front_d;
            back_q     <= back_d;
            rdata_q    <= rdata_d;
            rd_widx_q  <= rd_widx_d;
            tag_rmw_q  <= tag_rmw_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            sd_addr_q  <= sd_addr_d;
            sd_wdata_q <= sd_wdata_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_widx_q[wptr_q[AW-1:0]]  <= req_widx;
            fifo_wdata_q[wptr_q[AW-1:0]] <= fb_mem_wdata;
            fifo_wstrb_q[wptr_q[AW-1:0]] <= fb_mem_wstrb;
        end
    end

endmodule

// File: tb/tb_fb_sdram_bridge.sv
// Testbench for fb_sdram_bridge: directed scenarios plus randomized CPU traffic, checked against
// a word-level framebuffer model and an SDRAM responder with protocol monitors.
module tb_fb_sdram_bridge;

    localparam logic [23:0] FB_BASE  = 24'h200000;
    localparam int          FB_WORDS = 38400;
    localparam int          TIMEOUT  = 2000;

    typedef logic [56:0] cmd_t;  // {is_wr, addr[23:0], wdata[31:0]}

    logic        clk;
    logic        reset;
    logic        fb_mem_valid;
    logic [31:0] fb_mem_addr;
    logic [31:0] fb_mem_wdata;
    logic [3:0]  fb_mem_wstrb;
    logic [31:0] fb_mem_rdata;
    logic        fb_mem_ready;
    logic        sd_rd;
    logic        sd_wr;
    logic [23:0] sd_addr;
    logic [31:0] sd_wdata;
    logic [31:0] sd_rdata;
    logic        sd_busy;
    logic        sd_rdata_valid;
    logic        fb_idle;

    int n_checks = 0;
    int n_fail = 0;
    int proto_viol = 0;
    int ready_viol = 0;
    int ready_cnt = 0;
    logic ready_prev = 1'b0;

    logic force_busy = 1'b0;
    logic hold_rd = 1'b0;
    int inject_req = 0;
    int inject_seen = 0;

    logic [31:0] sdram_mem [int];
    logic [31:0] ref_mem [int];
    cmd_t cmd_log [$];

    fb_sdram_bridge #(
        .FIFO_DEPTH (4),
        .FB_BASE    (FB_BASE),
        .FB_WORDS   (FB_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fb_mem_valid   (fb_mem_valid),
        .fb_mem_addr    (fb_mem_addr),
        .fb_mem_wdata   (fb_mem_wdata),
        .fb_mem_wstrb   (fb_mem_wstrb),
        .fb_mem_rdata   (fb_mem_rdata),
        .fb_mem_ready   (fb_mem_ready),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_addr        (sd_addr),
        .sd_wdata       (sd_wdata),
        .sd_rdata       (sd_rdata),
        .sd_busy        (sd_busy),
        .sd_rdata_valid (sd_rdata_valid),
        .fb_idle        (fb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [23:0] a);
        return {8'hC3, a} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [31:0] sd_read(input logic [23:0] a);
        if (sdram_mem.exists(int'(a))) return sdram_mem[int'(a)];
        return init_word(a);
    endfunction

    // Expected CPU-visible word: last merged write, else the SDRAM's initial content.
    function automatic logic [31:0] ref_read(input int widx);
        logic [23:0] a;
        if (widx >= FB_WORDS) return 32'h0;
        if (ref_mem.exists(widx)) return ref_mem[widx];
        a = FB_BASE + widx[23:0];
        return init_word(a);
    endfunction

    always @(negedge clk) begin
        if (fb_mem_ready) ready_cnt <= ready_cnt + 1;
        if (fb_mem_ready && ready_prev) ready_viol <= ready_viol + 1;
        ready_prev <= fb_mem_ready;
    end

    // SDRAM controller model: read latency 1..4, busy for 1..3 cycles after each write.
    initial begin : sdram_model
        int          rd_cnt;
        int          busy_cnt;
        int          a;
        logic [23:0] rd_addr;
        logic        prev_rd;
        logic        prev_wr;
        rd_cnt = 0;
        busy_cnt = 0;
        rd_addr = '0;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        sd_busy = 1'b0;
        sd_rdata_valid = 1'b0;
        sd_rdata = '0;
        forever begin
            @(negedge clk);
            sd_rdata_valid = 1'b0;
            if (reset) begin
                rd_cnt = 0;
                busy_cnt = 0;
                prev_rd = 1'b0;
                prev_wr = 1'b0;
            end else begin
                if (inject_req != inject_seen) begin
                    inject_seen = inject_req;
                    sd_rdata_valid = 1'b1;
                    sd_rdata = 32'hCAFE_F00D;
                end
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        sd_rdata_valid = 1'b1;
                        sd_rdata = sd_read(rd_addr);
                    end
                end
                if (busy_cnt > 0) busy_cnt--;
                if (sd_rd || sd_wr) begin
                    a = int'(sd_addr);
                    if (sd_rd && sd_wr) proto_viol++;
                    if (a < int'(FB_BASE) || a >= int'(FB_BASE) + FB_WORDS) proto_viol++;
                end
                if (sd_rd && sd_busy) proto_viol++;
                if ((sd_rd && prev_rd) || (sd_wr && prev_wr)) proto_viol++;
                if (sd_rd) begin
                    cmd_log.push_back({1'b0, sd_addr, 32'h0});
                    if (!hold_rd) begin
                        rd_cnt = $urandom_range(1, 4);
                        rd_addr = sd_addr;
                    end
                end
                if (sd_wr) begin
                    cmd_log.push_back({1'b1, sd_addr, sd_wdata});
                    sdram_mem[int'(sd_addr)] = sd_wdata;
                    busy_cnt = $urandom_range(1, 3);
                end
                prev_rd = sd_rd;
                prev_wr = sd_wr;
            end
            sd_busy = force_busy || (busy_cnt > 0);
        end
    end

    // One CPU transaction; lat = cycles from valid to ready (1 = immediate acceptance).
    task automatic cpu_access(input logic [16:0] widx, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic [31:0] rdata,
                              output int lat);
        logic [1:0] lo;
        @(negedge clk);
        lo = 2'($urandom_range(0, 3));
        fb_mem_valid = 1'b1;
        fb_mem_addr  = 32'h2800_0000 | {13'd0, widx, lo};
        fb_mem_wdata = wdata;
        fb_mem_wstrb = wstrb;
        lat = 0;
        while (lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            if (fb_mem_ready) break;
        end
        check_eq($sformatf("ready[%0d]", widx), fb_mem_ready, 1);
        rdata = fb_mem_rdata;
        @(negedge clk);
        fb_mem_valid = 1'b0;
        fb_mem_wstrb = 4'h0;
    endtask

    task automatic do_write(input int widx, input logic [31:0] wdata, input logic [3:0] wstrb,
                            output int lat);
        logic [31:0] rd;
        logic [31:0] w;
        cpu_access(widx[16:0], wdata, wstrb, rd, lat);
        check_eq($sformatf("wr_rdata[%0d]", widx), rd, 0);
        if (widx < FB_WORDS) begin
            w = ref_read(widx);
            for (int i = 0; i < 4; i++) if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
            ref_mem[widx] = w;
        end
    endtask

    task automatic do_read(input int widx, output logic [31:0] rd);
        int lat;
        cpu_access(widx[16:0], $urandom, 4'h0, rd, lat);
        check_eq($sformatf("rd_data[%0d]", widx), rd, ref_read(widx));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!fb_idle && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check_eq("fb_idle", fb_idle, 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"}, fb_mem_ready, 0);
        check_eq({pfx, "_rdata"}, fb_mem_rdata, 0);
        check_eq({pfx, "_sd_rd"}, sd_rd, 0);
        check_eq({pfx, "_sd_wr"}, sd_wr, 0);
        check_eq({pfx, "_sd_addr"}, sd_addr, 0);
        check_eq({pfx, "_sd_wdata"}, sd_wdata, 0);
        check_eq({pfx, "_fb_idle"}, fb_idle, 1);
    endtask

    initial begin : main
        int          lat;
        int          lat5;
        int          b;
        int          widx;
        int          r;
        int          rc;
        bit          done5;
        logic [3:0]  ws;
        logic [31:0] rd;

        reset = 1'b1;
        fb_mem_valid = 1'b0;
        fb_mem_addr = '0;
        fb_mem_wdata = '0;
        fb_mem_wstrb = '0;
        done5 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Posted full-word write.
        b = cmd_log.size();
        do_write(5, 32'hDEAD_BEEF, 4'hF, lat);
        check_eq("post_lat", lat, 1);
        wait_idle();
        check_eq("post_ncmd", cmd_log.size() - b, 1);
        if (cmd_log.size() > b) check_eq("post_cmd", cmd_log[b], {1'b1, 24'h200005, 32'hDEAD_BEEF});

        // Byte-lane read-modify-write.
        sdram_mem[int'(24'h200010)] = 32'h1122_3344;
        ref_mem[16] = 32'h1122_3344;
        b = cmd_log.size();
        do_write(16, 32'hAABB_CCDD, 4'b0101, lat);
        wait_idle();
        check_eq("rmw_ncmd", cmd_log.size() - b, 2);
        if (cmd_log.size() > b + 1) begin
            check_eq("rmw_rd", cmd_log[b], {1'b0, 24'h200010, 32'h0});
            check_eq("rmw_wr", cmd_log[b+1], {1'b1, 24'h200010, 32'h11BB_33DD});
        end

        // Backpressure: busy stuck high, four writes fit, the fifth waits for a pop.
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_write(48 + i, 32'h5000_0000 + i, 4'hF, lat);
            check_eq($sformatf("bp_lat%0d", i), lat, 1);
        end
        fork
            begin
                do_write(52, 32'h5000_0004, 4'hF, lat5);
                done5 = 1'b1;
            end
            begin
                repeat (20) @(negedge clk);
                check_eq("bp_fifth_blocked", done5, 0);
                force_busy = 1'b0;
            end
        join
        check_eq("bp_fifth_late", lat5 > 15, 1);
        wait_idle();

        // Ordering: read of the second queued write sees its data after both writes land.
        b = cmd_log.size();
        do_write(32, 32'h1234_5678, 4'hF, lat);
        do_write(33, 32'h9ABC_DEF0, 4'hF, lat);
        do_read(33, rd);
        check_eq("ord_rdata", rd, 32'h9ABC_DEF0);
        check_eq("ord_ncmd", cmd_log.size() - b, 3);
        if (cmd_log.size() > b + 2) begin
            check_eq("ord_wr0", cmd_log[b], {1'b1, 24'h200020, 32'h1234_5678});
            check_eq("ord_wr1", cmd_log[b+1], {1'b1, 24'h200021, 32'h9ABC_DEF0});
            check_eq("ord_rd", cmd_log[b+2], {1'b0, 24'h200021, 32'h0});
        end

        // Out of range: acknowledged, read returns 0, no SDRAM traffic.
        b = cmd_log.size();
        do_write(FB_WORDS, 32'hFFFF_FFFF, 4'hF, lat);
        do_read(FB_WORDS, rd);
        repeat (5) @(negedge clk);
        check_eq("oor_ncmd", cmd_log.size() - b, 0);

        // Randomized traffic over a small address set including the last valid word.
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 19);
            if (r < 16) widx = r;
            else if (r < 18) widx = FB_WORDS - 1;
            else widx = FB_WORDS + $urandom_range(0, 5);
            if ($urandom_range(0, 9) < 4) begin
                do_read(widx, rd);
            end else begin
                ws = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(1, 15));
                do_write(widx, $urandom, ws, lat);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // Reset while a CPU read is in B_RD; a late rdata_valid must be ignored.
        hold_rd = 1'b1;
        @(negedge clk);
        fb_mem_valid = 1'b1;
        fb_mem_addr = 32'h2800_000C;
        fb_mem_wstrb = 4'h0;
        r = 0;
        while (!sd_rd && r < 20) begin
            @(negedge clk);
            r++;
        end
        check_eq("mid_rd_issued", sd_rd, 1);
        @(negedge clk);
        reset = 1'b1;
        fb_mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_rd = 1'b0;
        rc = ready_cnt;
        inject_req++;
        repeat (10) @(negedge clk);
        check_eq("mid_no_ready", ready_cnt - rc, 0);
        check_reset_outputs("mid");

        // SDRAM must hold every word the model expects.
        foreach (ref_mem[k]) begin
            check_eq($sformatf("mem[%0d]", k), sd_read(FB_BASE + k[23:0]), ref_mem[k]);
        end
        check_eq("proto_viol", proto_viol, 0);
        check_eq("ready_viol", ready_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
